// File: rtl/aes_pkg.sv
// Shared AES types plus GF(2^8) helpers that build the forward and inverse S-box
// functions from the field inverse and the affine transform.
package aes_pkg;
    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned AES_BYTES   = 16;

    typedef logic [7:0] aes_byte_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} sb_state_e;

    function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t b);
        aes_byte_t p;
        aes_byte_t s;
        p = 8'h00;
        s = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ s;
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse and conveniently maps 0 to 0
    function automatic aes_byte_t gf_inv(input aes_byte_t a);
        aes_byte_t sq;
        aes_byte_t r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic aes_byte_t sbox_fwd(input aes_byte_t a);
        aes_byte_t b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
               ^ 8'h63;
    endfunction

    function automatic aes_byte_t sbox_inv(input aes_byte_t s);
        aes_byte_t b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction
endpackage

// File: rtl/inv_sbox.sv
// Inverse AES S-box lane, same port shape as sbox; only present with AES_INV_SBOX_EN.
`ifdef AES_INV_SBOX_EN
module inv_sbox
    import aes_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    output aes_byte_t  sbout
);
    assign sbout = sbox_inv({y, x});
endmodule
`endif

// File: rtl/sbox.sv
// Forward AES S-box lane; x is the low nibble and y the high nibble of the input byte.
module sbox
    import aes_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    output aes_byte_t  sbout
);
    assign sbout = sbox_fwd({y, x});
endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative handshaked SubBytes: LANES bytes per clock over one held 128-bit state.
// Define AES_INV_SBOX_EN to add inv_i and per-lane inverse S-boxes.
module sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [AES_BLOCK_W-1:0] data_i,
`ifdef AES_INV_SBOX_EN
    input  logic                   inv_i,
`endif
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [AES_BLOCK_W-1:0] data_o
);
    localparam int unsigned BEATS = AES_BYTES / LANES;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    sb_state_e                   state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    aes_byte_t [AES_BYTES-1:0]   data_q, data_d;
    logic [3:0]                  lane_idx [LANES];
    aes_byte_t                   lane_in  [LANES];
    aes_byte_t                   lane_out [LANES];
`ifdef AES_INV_SBOX_EN
    logic                        inv_q, inv_d;
`endif

    // Byte-select mux: beat b feeds bytes b*LANES .. b*LANES+LANES-1 to the lanes
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l] = 4'(32'(cnt_q) * LANES + 32'(l));
            lane_in[l]  = data_q[lane_idx[l]];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        aes_byte_t fwd_out;
        sbox u_sbox (
            .x     (lane_in[l][3:0]),
            .y     (lane_in[l][7:4]),
            .sbout (fwd_out)
        );
`ifdef AES_INV_SBOX_EN
        aes_byte_t inv_out;
        inv_sbox u_inv_sbox (
            .x     (lane_in[l][3:0]),
            .y     (lane_in[l][7:4]),
            .sbout (inv_out)
        );
        assign lane_out[l] = inv_q ? inv_out : fwd_out;
`else
        assign lane_out[l] = fwd_out;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
`ifdef AES_INV_SBOX_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
`ifdef AES_INV_SBOX_EN
            inv_q   <= inv_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
`ifdef AES_INV_SBOX_EN
        inv_d   = inv_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    data_d  = data_i;
`ifdef AES_INV_SBOX_EN
                    inv_d   = inv_i;
`endif
                end
            end
            BUSY: begin
                for (int l = 0; l < LANES; l++) begin
                    data_d[lane_idx[l]] = lane_out[l];
                end
                if (cnt_q == LAST_BEAT) state_d = DONE;
                else                    cnt_d   = cnt_q + 1'b1;
            end
            DONE: begin
                if (ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state_q == IDLE);
        valid_o = (state_q == DONE);
        data_o  = data_q;
    end
endmodule

// File: tb/tb_sub_bytes_iter.sv
// Randomised bench for sub_bytes_iter: one instance per legal LANES, checked against
// a table-driven SubBytes model.
`timescale 1ns/1ps
module tb_sub_bytes_iter;
    localparam int NI = 5;

    localparam logic [7:0] SBOX_TAB [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         vin  [NI];
    logic         rin  [NI];
    logic         rdy  [NI];
    logic         vout [NI];
    logic [127:0] din  [NI];
    logic [127:0] dout [NI];
`ifdef AES_INV_SBOX_EN
    logic         inv  [NI];
`endif

    logic [7:0] inv_tab [256];
    int n_cmp = 0;
    int n_err = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sub_bytes_iter #(.LANES(1 << g)) u_dut (
            .clk_i   (clk),
            .rst_n_i (rst_n),
            .valid_i (vin[g]),
            .ready_o (rdy[g]),
            .data_i  (din[g]),
`ifdef AES_INV_SBOX_EN
            .inv_i   (inv[g]),
`endif
            .valid_o (vout[g]),
            .ready_i (rin[g]),
            .data_o  (dout[g])
        );
    end

    function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic iv);
        logic [15:0][7:0] b;
        b = d;
        for (int k = 0; k < 16; k++) b[k] = iv ? inv_tab[b[k]] : SBOX_TAB[b[k]];
        return b;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered at a negedge; returns 1ns after the acceptance edge.
    task automatic send(input int k, input logic [127:0] d);
        int n;
        n = 0;
        while (rdy[k] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", rdy[k], 1'b1);
        vin[k] = 1'b1;
        din[k] = d;
        @(posedge clk);
        #1;
        vin[k] = 1'b0;
    endtask

    // Counts edges since acceptance until valid_o; returns at a negedge.
    task automatic collect(input int k, output logic [127:0] res, output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (vout[k] === 1'b1) break;
        end
        check("valid_seen", vout[k], 1'b1);
        res = dout[k];
    endtask

    task automatic drain(input int k);
        rin[k] = 1'b1;
        check("hs_ready_low", rdy[k], 1'b0);
        @(posedge clk);
        #1;
        rin[k] = 1'b0;
        check("idle_ready", rdy[k], 1'b1);
        check("idle_valid", vout[k], 1'b0);
        @(negedge clk);
    endtask

    task automatic do_block(input int k, input logic [127:0] d, input logic iv, input string tag,
                            output logic [127:0] res, output int lat);
`ifdef AES_INV_SBOX_EN
        inv[k] = iv;
`endif
        send(k, d);
        collect(k, res, lat);
        check({tag, "_data"}, res, ref_sub(d, iv));
        drain(k);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d, res, exp, back;
        int lat;
        for (int i = 0; i < 256; i++) inv_tab[SBOX_TAB[i]] = 8'(i);
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            vin[k] = 1'b0;
            rin[k] = 1'b0;
            din[k] = '0;
`ifdef AES_INV_SBOX_EN
            inv[k] = 1'b0;
`endif
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_ready_%0d", k), rdy[k], 1'b1);
            check($sformatf("rst_valid_%0d", k), vout[k], 1'b0);
            check($sformatf("rst_data_%0d", k), dout[k], 128'h0);
        end

        // All-zero block on LANES=4
        do_block(2, 128'h0, 1'b0, "zero", res, lat);
        check("zero_latency", 128'(lat), 128'd4);
        check("zero_const", res, {16{8'h63}});

        // Single 0x53 byte at positions 0, 5, 15
        foreach (d[i]) d[i] = 1'b0;
        for (int j = 0; j < 3; j++) begin
            int p;
            p = (j == 0) ? 0 : (j == 1) ? 5 : 15;
            d = '0;
            d[8*p +: 8] = 8'h53;
            exp = {16{8'h63}};
            exp[8*p +: 8] = 8'hed;
            do_block(2, d, 1'b0, $sformatf("byte53_%0d", p), res, lat);
            check($sformatf("byte53_const_%0d", p), res, exp);
        end

        // Backpressure: result held for 10 cycles, then back-to-back acceptance
        d = {$urandom, $urandom, $urandom, $urandom};
        exp = ref_sub(d, 1'b0);
        send(2, d);
        collect(2, res, lat);
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", vout[2], 1'b1);
            check("bp_data", dout[2], exp);
            check("bp_ready", rdy[2], 1'b0);
            @(negedge clk);
        end
        drain(2);
        d = {$urandom, $urandom, $urandom, $urandom};
        send(2, d);
        check("b2b_busy", rdy[2], 1'b0);
        collect(2, res, lat);
        check("b2b_data", res, ref_sub(d, 1'b0));
        check("b2b_latency", 128'(lat), 128'd4);
        drain(2);

        // Reset in the middle of beat 2
        d = {$urandom, $urandom, $urandom, $urandom};
        send(2, d);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", vout[2], 1'b0);
        check("midrst_ready", rdy[2], 1'b1);
        check("midrst_data", dout[2], 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        d = {$urandom, $urandom, $urandom, $urandom};
        do_block(2, d, 1'b0, "post_rst", res, lat);
        check("post_rst_latency", 128'(lat), 128'd4);

        // Sweep every LANES value with random blocks
        for (int g = 0; g < NI; g++) begin
            for (int n = 0; n < 100; n++) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                do_block(g, d, 1'b0, $sformatf("sweep_l%0d", 1 << g), res, lat);
                check($sformatf("sweep_lat_l%0d", 1 << g), 128'(lat), 128'(16 >> g));
            end
        end

`ifdef AES_INV_SBOX_EN
        do_block(2, {16{8'h63}}, 1'b1, "inv_const", res, lat);
        check("inv_const_zero", res, 128'h0);
        for (int g = 0; g < NI; g++) begin
            for (int n = 0; n < 20; n++) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                do_block(g, d, 1'b0, "rt_fwd", res, lat);
                do_block(g, res, 1'b1, "rt_inv", back, lat);
                check($sformatf("roundtrip_l%0d", 1 << g), back, d);
            end
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
